// File: rtl/contour_seed_finder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | contour_seed_finder_pkg                                                    |
// | Frame geometry, widths and shared types for the seed finder and tracer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package contour_seed_finder_pkg;

  localparam int H_PIXELS     = 640;
  localparam int V_PIXELS     = 480;
  localparam int FRAME_PIXELS = H_PIXELS * V_PIXELS;
  localparam int ADDR_W       = 19;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int BIN_W        = 3;
  localparam int COUNT_W      = 12;
  localparam int RD_LATENCY   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr;
    logic              interior;
  } tag_t;

  // The tracer probes +/-1 and +/-row without bounds checks, so border pixels never qualify.
  function automatic logic is_interior(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                       input int h, input int v);
    return (x != '0) && (x != X_W'(h - 1)) && (y != '0) && (y != Y_W'(v - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/contour_seed_finder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | contour_seed_finder_if                                                     |
// | Control, BRAM read port and seed/result bundle of the seed finder.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface contour_seed_finder_if
  import contour_seed_finder_pkg::*;
#(
  parameter int COUNT_W = contour_seed_finder_pkg::COUNT_W
);
  logic               start;
  logic [ADDR_W-1:0]  addr;
  logic [BIN_W-1:0]   rd_data;
  logic               busy;
  logic               done;
  logic               found;
  logic               saturated;
  logic [X_W-1:0]     x_start;
  logic [Y_W-1:0]     y_start;
  logic [ADDR_W-1:0]  addr_start;
  logic [COUNT_W-1:0] num_pixels;

  modport master (
    input  start, rd_data,
    output addr, busy, done, found, saturated, x_start, y_start, addr_start, num_pixels
  );

  modport slave (
    output start, rd_data,
    input  addr, busy, done, found, saturated, x_start, y_start, addr_start, num_pixels
  );
endinterface
`default_nettype wire

// File: rtl/contour_seed_finder_raster_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | raster_addr_gen                                                            |
// | Raster x/y/linear address counters with last-pixel and interior flags.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module raster_addr_gen
  import contour_seed_finder_pkg::*;
#(
  parameter int H_PIXELS = contour_seed_finder_pkg::H_PIXELS,
  parameter int V_PIXELS = contour_seed_finder_pkg::V_PIXELS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              advance,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              interior
);

  localparam logic [X_W-1:0]    c_x_last    = X_W'(H_PIXELS - 1);
  localparam logic [ADDR_W-1:0] c_addr_last = ADDR_W'(H_PIXELS * V_PIXELS - 1);

  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_addr;

  // Linear address runs alongside x/y so no y*H multiply is needed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (clear) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (advance) begin
      r_addr <= r_addr + 1'b1;
      if (r_x == c_x_last) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign x        = r_x;
  assign y        = r_y;
  assign addr     = r_addr;
  assign last     = (r_addr == c_addr_last);
  assign interior = is_interior(r_x, r_y, H_PIXELS, V_PIXELS);

endmodule
`default_nettype wire

// File: rtl/contour_seed_finder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | contour_seed_finder                                                        |
// | Scans one frame, captures the first interior edge pixel, counts them all.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module contour_seed_finder
  import contour_seed_finder_pkg::*;
#(
  parameter int H_PIXELS   = contour_seed_finder_pkg::H_PIXELS,
  parameter int V_PIXELS   = contour_seed_finder_pkg::V_PIXELS,
  parameter int RD_LATENCY = contour_seed_finder_pkg::RD_LATENCY,
  parameter int COUNT_W    = contour_seed_finder_pkg::COUNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  contour_seed_finder_if.master bus
);

  localparam logic [COUNT_W-1:0] c_count_max = {COUNT_W{1'b1}};

  state_t r_state;
  state_t w_state_nxt;

  logic              w_clear;
  logic              w_advance;
  logic              w_push;
  logic              w_pipe_busy;
  logic              w_hit;
  logic [X_W-1:0]    w_x;
  logic [Y_W-1:0]    w_y;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;
  logic              w_interior;

  tag_t w_tag_in;
  tag_t w_tail;
  tag_t r_tag [RD_LATENCY];

  logic               r_found;
  logic               r_saturated;
  logic [X_W-1:0]     r_x_start;
  logic [Y_W-1:0]     r_y_start;
  logic [ADDR_W-1:0]  r_addr_start;
  logic [COUNT_W-1:0] r_num_pixels;

  raster_addr_gen #(
    .H_PIXELS (H_PIXELS),
    .V_PIXELS (V_PIXELS)
  ) u_addr_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (w_clear),
    .advance  (w_advance),
    .x        (w_x),
    .y        (w_y),
    .addr     (w_addr),
    .last     (w_last),
    .interior (w_interior)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_advance   = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_state_nxt = SCAN;
          w_clear     = 1'b1;
        end
      end
      SCAN: begin
        // Counters freeze on the last pixel so addr holds the final address through DRAIN.
        w_push    = 1'b1;
        w_advance = !w_last;
        if (w_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!w_pipe_busy) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_tag_in          = '0;
    w_tag_in.valid    = w_push;
    w_tag_in.x        = w_x;
    w_tag_in.y        = w_y;
    w_tag_in.addr     = w_addr;
    w_tag_in.interior = w_interior;
  end

  // Tags travel alongside the BRAM read so the tail lines up with rd_data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_comb begin
    w_pipe_busy = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) w_pipe_busy = w_pipe_busy | r_tag[i].valid;
  end

  assign w_tail = r_tag[RD_LATENCY-1];
  assign w_hit  = w_tail.valid && w_tail.interior && (bus.rd_data != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_found      <= 1'b0;
      r_saturated  <= 1'b0;
      r_x_start    <= '0;
      r_y_start    <= '0;
      r_addr_start <= '0;
      r_num_pixels <= '0;
    end else if (w_clear) begin
      r_found      <= 1'b0;
      r_saturated  <= 1'b0;
      r_x_start    <= '0;
      r_y_start    <= '0;
      r_addr_start <= '0;
      r_num_pixels <= '0;
    end else if (w_hit) begin
      if (r_num_pixels == c_count_max) r_saturated  <= 1'b1;
      else                             r_num_pixels <= r_num_pixels + 1'b1;
      if (!r_found) begin
        r_found      <= 1'b1;
        r_x_start    <= w_tail.x;
        r_y_start    <= w_tail.y;
        r_addr_start <= w_tail.addr;
      end
    end
  end

  assign bus.addr       = w_addr;
  assign bus.busy       = (r_state == SCAN) || (r_state == DRAIN);
  assign bus.done       = (r_state == DONE);
  assign bus.found      = r_found;
  assign bus.saturated  = r_saturated;
  assign bus.x_start    = r_x_start;
  assign bus.y_start    = r_y_start;
  assign bus.addr_start = r_addr_start;
  assign bus.num_pixels = r_num_pixels;

endmodule
`default_nettype wire
